ksa32_top: RTL and testbench

//   32-bit Kogge-Stone parallel-prefix adder with registered outputs.

---
 rtl/ksa32_top.sv | 49 ++++
 tb/tb_ksa32_top.sv | 109 ++++++++++
 2 files changed

// File: rtl/ksa32_top.sv
// ksa32_top: 32-bit Kogge-Stone adder (carry-in 0) with registered sum, carry-out and signed overflow
module ksa32_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] SUM,
    output logic        COUT,
    output logic        overflow
);
    logic [5:0][31:0] g;
    logic [3:0][31:0] p;
    logic [31:0]      sum;
    logic             cout, ovf;
    assign g[0] = A & B;
    assign p[0] = A ^ B;
    for (genvar l = 0; l < 5; l++) begin : lvl
        for (genvar i = 0; i < 32; i++) begin : bit_
            if (i < (1 << l)) begin : pass
                assign g[l+1][i] = g[l][i];
                if (l < 3) begin : pp
                    assign p[l+1][i] = p[l][i];
                end
            end else if (l < 4) begin : comb
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                if (l < 3) begin : pp
                    assign p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
                end
            end else begin : last
                // level-4 propagate is only needed here, so it is formed inline
                assign g[5][i] = g[4][i] | (p[3][i] & p[3][i-8] & g[4][i-16]);
            end
        end
    end
    assign sum  = p[0] ^ {g[5][30:0], 1'b0};
    assign cout = g[5][31];
    assign ovf  = g[5][31] ^ g[5][30];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SUM      <= '0;
            COUT     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            SUM      <= sum;
            COUT     <= cout;
            overflow <= ovf;
        end
    end
endmodule

// File: tb/tb_ksa32_top.sv
// tb_ksa32_top: scoreboard bench for ksa32_top with an arithmetic reference model
module tb_ksa32_top;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [31:0] SUM;
    logic        COUT, overflow;
    int          checks = 0, errors = 0;
    logic [33:0] q[$];

    ksa32_top dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B),
        .SUM(SUM), .COUT(COUT), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        s = {1'b0, a} + {1'b0, b};
        q.push_back({s[32], (a[31] == b[31]) && (s[31] != a[31]), s[31:0]});
    endtask

    task automatic check_rst(input string name);
        checks++;
        if ({SUM, COUT, overflow} !== 34'h0) begin
            errors++;
            $display("FAIL %s got SUM=%h COUT=%b overflow=%b want all zero", name, SUM, COUT, overflow);
        end
    endtask

    // monitor: each entry pushed in the previous cycle is due right after this edge
    initial begin
        logic [33:0] e;
        forever begin
            @(posedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                #3;
                checks++;
                if ({COUT, overflow, SUM} !== e) begin
                    errors++;
                    $display("FAIL result got SUM=%h COUT=%b overflow=%b want SUM=%h COUT=%b overflow=%b",
                             SUM, COUT, overflow, e[31:0], e[33], e[32]);
                end
            end
        end
    end

    initial begin
        logic [31:0] a, b;
        A = 32'hFFFFFFFF;
        B = 32'hFFFFFFFF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_rst("async_reset");
        @(posedge clk);
        #2;
        check_rst("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(32'h00000005, 32'h00000003);
        drive(32'hFFFFFFFF, 32'h00000001);
        drive(32'h7FFFFFFF, 32'h00000001);
        drive(32'h80000000, 32'h80000000);
        drive(32'hAAAAAAAA, 32'h55555555);
        drive(32'h00000000, 32'h00000000);
        drive(32'hFFFFFFFF, 32'hFFFFFFFF);
        drive(32'h80000000, 32'hFFFFFFFF);
        for (int n = 0; n < 10000; n++) begin
            a = $urandom;
            case ($urandom_range(3))
                0: b = ~a;
                1: b = ~a + 32'd1;
                default: b = $urandom;
            endcase
            drive(a, b);
        end
        drive(32'h12345678, 32'h9ABCDEF0);
        #4;
        rst_n = 1'b0;
        #1;
        check_rst("midstream_reset");
        q.delete();
        @(posedge clk);
        #2;
        check_rst("midstream_hold");
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) drive($urandom, $urandom);
        @(posedge clk);
        @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
